frame_tx_seq: RTL
=================

FRAME_TX_SEQ -- requirements
Module: frame_tx_seq

Interface
REQ-001 Parameter MAX_LEN, default 16: payload buffer depth in bytes.
REQ-002 Parameter AW, default 4: buffer address width, with 2^AW >= MAX_LEN.
REQ-003 Parameter LW, default 5: length field width, able to hold MAX_LEN.
REQ-004 Parameter CLK_FREQ, default 50000000: system clock in Hz.
REQ-005 Parameter BAUD_RATE, default 115200: UART bit rate.
REQ-006 Parameter GAP_BITS, default 39: post-frame silence in bit times (3.5 chars x 11 bits, rounded up).
REQ-007 clk_in  input  1  system clock; the block uses a single clock domain.
REQ-008 rst_in  input  1  reset, asynchronous and active-high.
REQ-009 wr_en  input  1  buffer write strobe.
REQ-010 wr_addr  input  AW  buffer write address.
REQ-011 wr_data  input  8  buffer write byte.
REQ-012 start  input  1  single-cycle frame launch request.
REQ-013 len  input  LW  payload byte count, sampled on start.
REQ-014 crc_en  input  1  append Modbus CRC-16; sampled on start.
REQ-015 abort  input  1  cancel the frame in progress.
REQ-016 tx_start  output  1  single-cycle byte launch to the UART byte transmitter.
REQ-017 tx_data  output  8  byte to send; stable from tx_start until tx_done.
REQ-018 tx_done  input  1  byte-complete pulse from the UART byte transmitter.
REQ-019 busy  output  1  high from accepted start until done, err or abort.
REQ-020 done  output  1  single-cycle pulse: frame and gap complete.
REQ-021 err  output  1  single-cycle pulse: start rejected.
REQ-022 crc_out  output  16  CRC of the last frame; valid when done is high.

Function
REQ-023 The state set SHALL be IDLE, SEND, WAIT, CRC_LO, CRC_HI, GAP.
REQ-024 IDLE: a write with wr_en=1 and wr_addr<MAX_LEN SHALL update buffer[wr_addr] on the next edge; otherwise the write SHALL be ignored.
REQ-025 IDLE + start + 1<=len<=MAX_LEN: the block SHALL latch len and crc_en, set index=0, set CRC=16'hFFFF, set busy=1, and go to SEND.
REQ-026 IDLE + start with len=0 or len>MAX_LEN: the block SHALL pulse err for 1 cycle, keep busy=0, send nothing and stay in IDLE.
REQ-027 SEND: the block SHALL assert tx_start for exactly 1 cycle and drive tx_data=buffer[index].
REQ-028 In the same cycle as REQ-027, CRC SHALL update over that byte: reflected polynomial 16'hA001, LSB-first, 8 shift steps in one cycle. Then go to WAIT.
REQ-029 WAIT: the block SHALL hold tx_data and ignore everything except tx_done and abort.
REQ-030 WAIT + tx_done, byte was payload: index SHALL increment, then:
- index<len -> SEND;
- index==len and crc_en=1 -> CRC_LO;
- index==len and crc_en=0 -> GAP.
REQ-031 CRC_LO SHALL send CRC[7:0], then WAIT; after tx_done go to CRC_HI.
REQ-032 CRC_HI SHALL send CRC[15:8], then WAIT; after tx_done go to GAP.
REQ-033 CRC bytes SHALL NOT be folded into CRC.
REQ-034 GAP SHALL count GAP_BITS*(CLK_FREQ/BAUD_RATE) cycles, using integer division.
REQ-035 At the end of the GAP count, the block SHALL pulse done, clear busy in the same cycle, load crc_out, and return to IDLE.
REQ-036 The first tx_start SHALL occur exactly 1 cycle after the accepted start.
REQ-037 Each following tx_start SHALL occur exactly 1 cycle after the previous tx_done.
REQ-038 start, wr_en and tx_done received while busy, other than a tx_done in WAIT, SHALL be ignored; the buffer is write-protected while busy.
REQ-039 abort in any non-IDLE state SHALL return the block to IDLE on the next edge with busy=0 and tx_start=0, with no done, no err and crc_out unchanged.
REQ-040 abort in IDLE SHALL have no effect. abort together with start in IDLE: abort wins and the frame is not accepted.
REQ-041 len==MAX_LEN SHALL send all MAX_LEN bytes, and index SHALL NOT wrap before comparison.

Reset
REQ-042 While rst_in=1, asynchronously: state=IDLE, tx_start=0, tx_data=8'h00, busy=0, done=0, err=0, crc_out=16'h0000, index=0, gap counter=0.
REQ-043 Buffer contents SHALL NOT be reset.
REQ-044 Reset in the middle of a frame SHALL abandon it with no done pulse.
REQ-045 After rst_in deasserts, the first start SHALL be accepted normally.

Verification
REQ-046 Load 01 03 00 01 00 01, len=6, crc_en=1 -> tx_data sequence 01 03 00 01 00 01 D5 CA, crc_out=16'hCAD5, done exactly 16926 cycles after the 8th tx_done (defaults).
REQ-047 Load 01 06 00 02 00 05, crc_en=1 -> trailing bytes E8 09; then 01 04 00 01 00 04 -> A0 09; crc_out correct for each frame.
REQ-048 len=6, crc_en=0 -> exactly 6 tx_start pulses, then gap, then done; start pulsed during the frame is ignored.
REQ-049 start with len=0, and with len=17 -> err 1 cycle, busy stays 0, no tx_start.
REQ-050 abort during byte 3 WAIT -> IDLE next cycle, no done. A following start sends a full frame with a correct CRC (CRC reinitialised).
REQ-051 Assert rst_in during GAP -> all outputs at reset values immediately, no done. A write while busy leaves the buffer unchanged, checked on the next frame.

Source files
------------

// File: rtl/frame_tx_seq.sv
// Frame transmit sequencer: streams a buffered payload to a UART byte transmitter,
// optionally appends a Modbus CRC-16, then enforces an inter-frame silence gap.
module frame_tx_seq #(
  parameter int unsigned MAX_LEN   = 16,
  parameter int unsigned AW        = 4,
  parameter int unsigned LW        = 5,
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 115200,
  parameter int unsigned GAP_BITS  = 39
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic          crc_en,
  input  logic          abort,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  input  logic          tx_done,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [15:0]   crc_out
);

  localparam int unsigned   GAP_CYCLES = GAP_BITS * (CLK_FREQ / BAUD_RATE);
  localparam int unsigned   GW         = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);
  localparam logic [AW:0]   ADDR_LIM   = (AW + 1)'(MAX_LEN);
  localparam logic [LW-1:0] LEN_MAX    = LW'(MAX_LEN);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, CRC_LO, CRC_HI, GAP} state_t;
  typedef enum logic [1:0] {K_PAYLOAD, K_CRC_LO, K_CRC_HI} kind_t;

  state_t        state;
  kind_t         kind;
  logic [7:0]    mem [0:MAX_LEN-1];
  logic [LW-1:0] index;
  logic [LW-1:0] next_index;
  logic [LW-1:0] len_q;
  logic          crc_en_q;
  logic [15:0]   crc;
  logic [GW-1:0] gap_cnt;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int unsigned i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r;
  endfunction

  assign next_index = index + LW'(1);

  // Payload buffer has no reset; it is write-protected outside IDLE.
  always_ff @(posedge clk_in) begin
    if (state == IDLE && wr_en && ({1'b0, wr_addr} < ADDR_LIM)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // tx_start/tx_data are registered on entry to SEND/CRC_LO/CRC_HI so the launch
  // pulse coincides with the one cycle spent in those states.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= IDLE;
      kind     <= K_PAYLOAD;
      tx_start <= 1'b0;
      tx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      crc_out  <= '0;
      index    <= '0;
      len_q    <= '0;
      crc_en_q <= 1'b0;
      crc      <= '1;
      gap_cnt  <= '0;
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      if (abort && state != IDLE) begin
        state   <= IDLE;
        busy    <= 1'b0;
        gap_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              if (len != '0 && len <= LEN_MAX) begin
                len_q    <= len;
                crc_en_q <= crc_en;
                index    <= '0;
                crc      <= 16'hFFFF;
                busy     <= 1'b1;
                kind     <= K_PAYLOAD;
                tx_start <= 1'b1;
                tx_data  <= mem[0];
                state    <= SEND;
              end else begin
                err <= 1'b1;
              end
            end
          end
          SEND: begin
            crc   <= crc16_byte(crc, tx_data);
            state <= WAIT;
          end
          CRC_LO, CRC_HI: state <= WAIT;
          WAIT: begin
            if (tx_done) begin
              case (kind)
                K_PAYLOAD: begin
                  index <= next_index;
                  if (next_index < len_q) begin
                    tx_start <= 1'b1;
                    tx_data  <= mem[next_index[AW-1:0]];
                    state    <= SEND;
                  end else if (crc_en_q) begin
                    tx_start <= 1'b1;
                    tx_data  <= crc[7:0];
                    kind     <= K_CRC_LO;
                    state    <= CRC_LO;
                  end else begin
                    gap_cnt <= GW'(1);
                    state   <= GAP;
                  end
                end
                K_CRC_LO: begin
                  tx_start <= 1'b1;
                  tx_data  <= crc[15:8];
                  kind     <= K_CRC_HI;
                  state    <= CRC_HI;
                end
                default: begin
                  gap_cnt <= GW'(1);
                  state   <= GAP;
                end
              endcase
            end
          end
          GAP: begin
            // The cycle that accepted the final tx_done is the first gap cycle.
            if (gap_cnt == GAP_LAST) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              crc_out <= crc;
              gap_cnt <= '0;
              state   <= IDLE;
            end else begin
              gap_cnt <= gap_cnt + GW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
